err_log: RTL

- Multi-source, synthesizable error-event logger.
- Successor to the single-source error-code monitor used in simulation; carries that monitor into silicon, generalised to NUM_SRC sources.
- Logs every transition of each source's error code into a timestamped FIFO that firmware drains over CSR.
- Keeps per-source sticky flags and a saturating drop counter.

---
 rtl/err_log_pkg.sv | 36 +++
 rtl/fifo_sync.sv | 71 +++++++
 rtl/err_log.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/err_log_pkg.sv
// Shared types for the error-event logger: log entry layout, firmware-visible error codes.
// No logic; widths here match the default err_log configuration.
package err_log_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int CODE_W_DEF  = 4;
    localparam int TS_W_DEF    = 32;
    localparam int SRC_W       = $clog2(NUM_SRC_DEF);

    typedef struct packed {
        logic [SRC_W-1:0]      src;
        logic [CODE_W_DEF-1:0] code;
        logic [TS_W_DEF-1:0]   ts;
    } entry_t;

    typedef enum logic [CODE_W_DEF-1:0] {
        ERROR_CLEARED       = 4'd0,
        UART_RX_OVERFLOW    = 4'd1,
        ANOTHER_CMD_PENDING = 4'd2,
        ANOTHER_CMD_IN_RX   = 4'd3,
        UNEXPECTED_CHAR     = 4'd4,
        ILLEGAL_CMD_CHAR    = 4'd5,
        INVALID_ANUM        = 4'd6,
        ADC0_CMD_DROPPED    = 4'd7,
        ADC1_CMD_DROPPED    = 4'd8,
        DAC0_CMD_DROPPED    = 4'd9,
        DAC1_CMD_DROPPED    = 4'd10,
        INVALID_CMD_ID      = 4'd11
    } err_code_e;

    // Index width that stays legal for a single-source build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Generic synchronous first-word-fall-through FIFO with registered full/empty/fill.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: push_rdy drops when full unless a pop frees a slot in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_nxt;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop_rdy & ~empty_q;
    assign push_rdy = ~full_q | do_pop;
    assign do_push  = push_vld & push_rdy;
    assign pop_vld  = ~empty_q;
    assign pop_dat  = mem[rd_ptr];
    assign fill     = fill_q;

    always_comb begin
        fill_nxt = fill_q;
        case ({do_push, do_pop})
            2'b10:   fill_nxt = fill_q + FW'(1);
            2'b01:   fill_nxt = fill_q - FW'(1);
            default: fill_nxt = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            fill_q  <= fill_nxt;
            full_q  <= (fill_nxt == FW'(DEPTH));
            empty_q <= (fill_nxt == '0);
        end
    end

endmodule

// File: rtl/err_log.sv
// Multi-source error-code transition logger: per-source pending slot, round-robin into a timestamped FIFO.
// Latency: two cycles from a code change to rd_valid, longer under contention or a full FIFO.
// Backpressure: full FIFO stalls grants; pending slots hold and later events overwrite them, counted in drop_cnt.
module err_log
    import err_log_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int CODE_W    = 4,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 32,
    parameter int LOG_CLEAR = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0][CODE_W-1:0]  src_err,
    input  logic                            clr,
    input  logic [NUM_SRC-1:0]              sticky_clr,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [idx_w(NUM_SRC)-1:0]       rd_src,
    output logic [CODE_W-1:0]               rd_code,
    output logic [TS_W-1:0]                 rd_ts,
    output logic [$clog2(DEPTH):0]          fill,
    output logic [NUM_SRC-1:0]              sticky,
    output logic [15:0]                     drop_cnt,
    output logic                            irq
);

    localparam int IDX_W = idx_w(NUM_SRC);

    typedef struct packed {
        logic [IDX_W-1:0]  src;
        logic [CODE_W-1:0] code;
        logic [TS_W-1:0]   ts;
    } log_entry_t;

    logic [TS_W-1:0]                  ts_q;
    logic [NUM_SRC-1:0][CODE_W-1:0]   prev_q;
    logic [NUM_SRC-1:0][CODE_W-1:0]   slot_code_q;
    logic [NUM_SRC-1:0][TS_W-1:0]     slot_ts_q;
    logic [NUM_SRC-1:0]               slot_vld_q;
    logic [NUM_SRC-1:0]               sticky_q;
    logic [15:0]                      drop_q;
    logic [IDX_W-1:0]                 rr_q;

    logic [NUM_SRC-1:0]               evt;
    logic [NUM_SRC-1:0]               sticky_set;
    logic [NUM_SRC-1:0]               ovr;
    logic [NUM_SRC-1:0]               gnt_oh;
    logic [IDX_W-1:0]                 gnt_idx;
    logic [IDX_W-1:0]                 cand;
    logic                             gnt_vld;
    logic [16:0]                      drop_sum;
    logic [15:0]                      drop_nxt;

    logic                             push_rdy;
    logic                             fifo_vld;
    log_entry_t                       push_dat;
    log_entry_t                       pop_dat;
    log_entry_t                       last_q;
    log_entry_t                       rd_ent;

    always_comb begin
        evt        = '0;
        sticky_set = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            evt[i]        = (src_err[i] != prev_q[i]) && ((src_err[i] != '0) || (LOG_CLEAR != 0));
            sticky_set[i] = evt[i] && (src_err[i] != '0);
        end
    end

    // Scan from the highest offset down so the slot closest to rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_SRC);
            if (slot_vld_q[cand] && push_rdy && !clr) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = gnt_vld;
    end

    always_comb begin
        ovr      = evt & slot_vld_q & ~gnt_oh;
        drop_sum = 17'(drop_q);
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_sum = drop_sum + 17'(ovr[i]);
        end
        drop_nxt = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        push_dat.src  = gnt_idx;
        push_dat.code = slot_code_q[gnt_idx];
        push_dat.ts   = slot_ts_q[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            prev_q      <= '0;
            slot_vld_q  <= '0;
            slot_code_q <= '0;
            slot_ts_q   <= '0;
            sticky_q    <= '0;
            drop_q      <= '0;
            rr_q        <= '0;
            last_q      <= '0;
        end else begin
            ts_q     <= ts_q + TS_W'(1);
            prev_q   <= src_err;
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
            if (fifo_vld) last_q <= pop_dat;
            if (clr) begin
                slot_vld_q <= '0;
                drop_q     <= '0;
            end else begin
                drop_q <= drop_nxt;
                if (gnt_vld) begin
                    rr_q <= (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
                end
                // A new event reloads the slot even when its old entry is granted this cycle.
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (evt[i]) begin
                        slot_vld_q[i]  <= 1'b1;
                        slot_code_q[i] <= src_err[i];
                        slot_ts_q[i]   <= ts_q;
                    end else if (gnt_oh[i]) begin
                        slot_vld_q[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    fifo_sync #(
        .WIDTH ($bits(log_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clr),
        .push_vld (gnt_vld),
        .push_rdy (push_rdy),
        .push_dat (push_dat),
        .pop_vld  (fifo_vld),
        .pop_rdy  (rd_ready),
        .pop_dat  (pop_dat),
        .fill     (fill)
    );

    // Head output holds the last presented entry once the FIFO drains.
    assign rd_ent   = fifo_vld ? pop_dat : last_q;
    assign rd_valid = fifo_vld;
    assign rd_src   = rd_ent.src;
    assign rd_code  = rd_ent.code;
    assign rd_ts    = rd_ent.ts;
    assign sticky   = sticky_q;
    assign drop_cnt = drop_q;
    assign irq      = fifo_vld | (drop_q != '0);

endmodule
